// File: rtl/hvac_pkg.sv
// rtl/hvac_pkg.sv - shared types and constants for the thermostat sequencer
package hvac_pkg;

  localparam int TEMP_W  = 7;
  localparam int MINTEMP = 18;
  localparam int MAXTEMP = 26;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HEAT     = 3'd1,
    ST_COOL     = 3'd2,
    ST_FAN_POST = 3'd3,
    ST_LOCKOUT  = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  // Lower threshold floors at zero so a small setpoint never wraps to a huge value
  function automatic logic [7:0] lo_thresh(input logic [7:0] sp, input logic [7:0] hyst);
    return (sp >= hyst) ? (sp - hyst) : 8'd0;
  endfunction

endpackage

// File: rtl/hvac_ctrl_if.sv
// rtl/hvac_ctrl_if.sv - setpoint/sensor inputs and relay outputs of the sequencer
interface hvac_ctrl_if;
  import hvac_pkg::*;

  logic              i_tick;
  logic              i_enable;
  logic [TEMP_W-1:0] i_setpoint;
  logic              i_temp_valid;
  logic [TEMP_W-1:0] i_temp_meas;
  logic              o_heat_on;
  logic              o_cool_on;
  logic              o_fan_on;
  logic              o_fault;
  logic [2:0]        o_state;

  modport master (
    output i_tick, i_enable, i_setpoint, i_temp_valid, i_temp_meas,
    input  o_heat_on, o_cool_on, o_fan_on, o_fault, o_state
  );

  modport slave (
    input  i_tick, i_enable, i_setpoint, i_temp_valid, i_temp_meas,
    output o_heat_on, o_cool_on, o_fan_on, o_fault, o_state
  );

endinterface

// File: rtl/hvac_ctrl_sensor_wdog.sv
// rtl/hvac_ctrl_sensor_wdog.sv - sensor sample capture and stall watchdog
module sensor_wdog
  import hvac_pkg::*;
#(
  parameter int SENSOR_TO = 10,
  parameter int CW        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_tick,
  input  logic              i_temp_valid,
  input  logic [TEMP_W-1:0] i_temp_meas,
  output logic [TEMP_W-1:0] o_meas_q,
  output logic              o_meas_ok,
  output logic              o_timeout
);

  localparam logic [CW-1:0] L_SENSOR_TO = CW'(SENSOR_TO);

  logic [TEMP_W-1:0] r_meas_q;
  logic              r_meas_ok;
  logic [CW-1:0]     r_wd_cnt;

  // A fresh sample outranks a tick landing in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meas_q  <= '0;
      r_meas_ok <= 1'b0;
      r_wd_cnt  <= '0;
    end else if (i_temp_valid) begin
      r_meas_q  <= i_temp_meas;
      r_meas_ok <= 1'b1;
      r_wd_cnt  <= '0;
    end else if (i_tick && (r_wd_cnt != '1)) begin
      r_wd_cnt  <= r_wd_cnt + 1'b1;
    end
  end

  assign o_meas_q  = r_meas_q;
  assign o_meas_ok = r_meas_ok;
  assign o_timeout = (r_wd_cnt == L_SENSOR_TO);

endmodule

// File: rtl/hvac_ctrl.sv
// rtl/hvac_ctrl.sv - thermostat sequencer driving heater, cooler and fan relays
module hvac_ctrl
  import hvac_pkg::*;
#(
  parameter int HYST      = 1,
  parameter int MIN_RUN   = 4,
  parameter int FAN_POST  = 3,
  parameter int MIN_OFF   = 6,
  parameter int SENSOR_TO = 10,
  parameter int CW        = 8
) (
  input  logic        clk,
  input  logic        reset,
  hvac_ctrl_if.slave  bus
);

  localparam logic [7:0]    L_HYST     = 8'(HYST);
  localparam logic [CW-1:0] L_MIN_RUN  = CW'(MIN_RUN);
  localparam logic [CW-1:0] L_FAN_POST = CW'(FAN_POST);
  localparam logic [CW-1:0] L_MIN_OFF  = CW'(MIN_OFF);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_tick_cnt;
  logic              r_heat_on, r_cool_on, r_fan_on, r_fault;
  logic              w_heat_nxt, w_cool_nxt, w_fan_nxt, w_fault_nxt;
  logic [TEMP_W-1:0] w_meas_q;
  logic              w_meas_ok;
  logic              w_timeout;
  logic [7:0]        w_sp, w_meas, w_lo, w_hi;
  logic              w_run_done, w_want_heat, w_want_cool;

  sensor_wdog #(
    .SENSOR_TO (SENSOR_TO),
    .CW        (CW)
  ) u_sensor_wdog (
    .clk          (clk),
    .reset        (reset),
    .i_tick       (bus.i_tick),
    .i_temp_valid (bus.i_temp_valid),
    .i_temp_meas  (bus.i_temp_meas),
    .o_meas_q     (w_meas_q),
    .o_meas_ok    (w_meas_ok),
    .o_timeout    (w_timeout)
  );

  assign w_sp        = {1'b0, bus.i_setpoint};
  assign w_meas      = {1'b0, w_meas_q};
  assign w_lo        = lo_thresh(w_sp, L_HYST);
  assign w_hi        = w_sp + L_HYST;
  assign w_run_done  = (r_tick_cnt >= L_MIN_RUN);
  assign w_want_heat = bus.i_enable && w_meas_ok && (w_meas <= w_lo);
  assign w_want_cool = bus.i_enable && w_meas_ok && (w_meas >= w_hi);

  always_comb begin
    w_state_nxt = r_state;
    // A stalled sensor overrides every other decision except while already faulted
    if (w_timeout && (r_state != ST_FAULT)) begin
      w_state_nxt = ST_FAULT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_want_heat)      w_state_nxt = ST_HEAT;
          else if (w_want_cool) w_state_nxt = ST_COOL;
        end
        ST_HEAT: begin
          if (!bus.i_enable || (w_run_done && (w_meas >= w_sp))) w_state_nxt = ST_FAN_POST;
        end
        ST_COOL: begin
          if (!bus.i_enable || (w_run_done && (w_meas <= w_sp))) w_state_nxt = ST_FAN_POST;
        end
        ST_FAN_POST: begin
          if (r_tick_cnt == L_FAN_POST) w_state_nxt = ST_LOCKOUT;
        end
        ST_LOCKOUT: begin
          if (r_tick_cnt == L_MIN_OFF) w_state_nxt = ST_IDLE;
        end
        ST_FAULT: begin
          if (bus.i_temp_valid) w_state_nxt = ST_LOCKOUT;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    w_heat_nxt  = 1'b0;
    w_cool_nxt  = 1'b0;
    w_fan_nxt   = 1'b0;
    w_fault_nxt = 1'b0;
    case (w_state_nxt)
      ST_HEAT:     begin w_heat_nxt = 1'b1; w_fan_nxt = 1'b1; end
      ST_COOL:     begin w_cool_nxt = 1'b1; w_fan_nxt = 1'b1; end
      ST_FAN_POST: w_fan_nxt   = 1'b1;
      ST_FAULT:    w_fault_nxt = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= '0;
      r_heat_on  <= 1'b0;
      r_cool_on  <= 1'b0;
      r_fan_on   <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_heat_on  <= w_heat_nxt;
      r_cool_on  <= w_cool_nxt;
      r_fan_on   <= w_fan_nxt;
      r_fault    <= w_fault_nxt;
      if (w_state_nxt != r_state)
        r_tick_cnt <= '0;
      else if (bus.i_tick && (r_tick_cnt != '1))
        r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  assign bus.o_state   = r_state;
  assign bus.o_heat_on = r_heat_on;
  assign bus.o_cool_on = r_cool_on;
  assign bus.o_fan_on  = r_fan_on;
  assign bus.o_fault   = r_fault;

endmodule

// File: tb/tb_hvac_ctrl.sv
// tb/tb_hvac_ctrl.sv - directed bench with a behavioural thermostat model
module tb_hvac_ctrl;

  localparam int HYST = 1, MIN_RUN = 4, FAN_POST = 3, MIN_OFF = 6, SENSOR_TO = 10;
  localparam int M_IDLE = 0, M_HEAT = 1, M_COOL = 2, M_POST = 3, M_LOCK = 4, M_FAULT = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hvac_ctrl_if bus ();

  hvac_ctrl #(
    .HYST(HYST), .MIN_RUN(MIN_RUN), .FAN_POST(FAN_POST),
    .MIN_OFF(MIN_OFF), .SENSOR_TO(SENSOR_TO), .CW(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;
  int room     = 0;

  // Behavioural model: mode, time spent in mode, ticks since last sample, last sample
  int m_st = 0, m_tc = 0, m_wd = 0, m_meas = 0;
  bit m_ok = 1'b0;

  always @(posedge clk or negedge reset) begin : model
    int sp, lo, hi, nst;
    if (!reset) begin
      m_st <= M_IDLE; m_tc <= 0; m_wd <= 0; m_meas <= 0; m_ok <= 1'b0;
    end else begin
      sp = int'(bus.i_setpoint);
      lo = sp - HYST;
      if (lo < 0) lo = 0;
      hi = sp + HYST;
      nst = m_st;
      if (m_st != M_FAULT && m_wd == SENSOR_TO) nst = M_FAULT;
      else if (m_st == M_IDLE && bus.i_enable && m_ok && m_meas <= lo) nst = M_HEAT;
      else if (m_st == M_IDLE && bus.i_enable && m_ok && m_meas >= hi) nst = M_COOL;
      else if (m_st == M_HEAT && (!bus.i_enable || (m_tc >= MIN_RUN && m_meas >= sp))) nst = M_POST;
      else if (m_st == M_COOL && (!bus.i_enable || (m_tc >= MIN_RUN && m_meas <= sp))) nst = M_POST;
      else if (m_st == M_POST && m_tc == FAN_POST) nst = M_LOCK;
      else if (m_st == M_LOCK && m_tc == MIN_OFF) nst = M_IDLE;
      else if (m_st == M_FAULT && bus.i_temp_valid) nst = M_LOCK;
      if (nst != m_st) m_tc <= 0;
      else if (bus.i_tick && m_tc < 255) m_tc <= m_tc + 1;
      if (bus.i_temp_valid) begin
        m_meas <= int'(bus.i_temp_meas); m_ok <= 1'b1; m_wd <= 0;
      end else if (bus.i_tick && m_wd < 255) begin
        m_wd <= m_wd + 1;
      end
      m_st <= nst;
    end
  end

  function automatic int code(int st, int h, int c, int f, int flt);
    return st * 16 + h * 8 + c * 4 + f * 2 + flt;
  endfunction

  function automatic int dut_code();
    return code(int'(bus.o_state), int'(bus.o_heat_on), int'(bus.o_cool_on),
                int'(bus.o_fan_on), int'(bus.o_fault));
  endfunction

  function automatic int model_code();
    return code(m_st, int'(m_st == M_HEAT), int'(m_st == M_COOL),
                int'(m_st == M_HEAT || m_st == M_COOL || m_st == M_POST), int'(m_st == M_FAULT));
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      n_checks++;
      if (dut_code() != model_code()) begin
        n_fail++;
        $display("FAIL cycle_compare t=%0t actual=0x%02h required=0x%02h", $time, dut_code(), model_code());
      end
      n_checks++;
      if (bus.o_heat_on && bus.o_cool_on) begin
        n_fail++;
        $display("FAIL heat_cool_exclusive t=%0t actual=1 required=0", $time);
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=0x%02h required=0x%02h", nm, $time, act, exp);
    end
  endtask

  task automatic cyc(input bit tk, input bit tv, input int t);
    @(negedge clk);
    bus.i_tick = tk;
    bus.i_temp_valid = tv;
    bus.i_temp_meas = 7'(t);
  endtask

  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, room);
      cyc(1'b0, 1'b1, room);
      cyc(1'b0, 1'b0, room);
    end
  endtask

  task automatic stall_tick(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, room);
      cyc(1'b0, 1'b0, room);
      cyc(1'b0, 1'b0, room);
    end
  endtask

  task automatic expect_st(input string nm, input int st, input int h, input int c, input int f, input int flt);
    cyc(1'b0, 1'b0, room);
    #1;
    check(nm, dut_code(), code(st, h, c, f, flt));
    check({nm, "_model"}, model_code(), code(st, h, c, f, flt));
  endtask

  initial begin
    reset = 1'b1;
    bus.i_tick = 1'b0; bus.i_enable = 1'b1; bus.i_setpoint = 7'd22;
    bus.i_temp_valid = 1'b0; bus.i_temp_meas = 7'd0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", dut_code(), 0);
    @(negedge clk);
    reset = 1'b1;
    chk_on = 1'b1;

    // Heat cycle
    room = 20;
    cyc(1'b0, 1'b1, room);
    cyc(1'b0, 1'b0, room);
    expect_st("heat_start", M_HEAT, 1, 0, 1, 0);
    do_tick(2);
    room = 22;
    do_tick(1);
    expect_st("heat_min_run_hold", M_HEAT, 1, 0, 1, 0);
    do_tick(1);
    expect_st("heat_to_post", M_POST, 0, 0, 1, 0);
    do_tick(3);
    expect_st("post_to_lockout", M_LOCK, 0, 0, 0, 0);
    do_tick(6);
    expect_st("lockout_to_idle_in_band", M_IDLE, 0, 0, 0, 0);

    // Cool cycle
    room = 23;
    do_tick(1);
    expect_st("cool_start", M_COOL, 0, 1, 1, 0);
    do_tick(4);
    expect_st("cool_hold_above_sp", M_COOL, 0, 1, 1, 0);
    room = 22;
    do_tick(1);
    expect_st("cool_to_post", M_POST, 0, 0, 1, 0);
    do_tick(9);
    expect_st("cool_back_idle", M_IDLE, 0, 0, 0, 0);

    // Lockout ignores heat demand
    room = 23;
    do_tick(1);
    expect_st("cool_again", M_COOL, 0, 1, 1, 0);
    room = 18;
    do_tick(4);
    expect_st("cool_exit_cold", M_POST, 0, 0, 1, 0);
    do_tick(3);
    expect_st("lockout_enter", M_LOCK, 0, 0, 0, 0);
    do_tick(5);
    expect_st("lockout_blocks_heat", M_LOCK, 0, 0, 0, 0);
    do_tick(1);
    expect_st("heat_after_lockout", M_HEAT, 1, 0, 1, 0);

    // Enable override
    do_tick(1);
    bus.i_enable = 1'b0;
    expect_st("enable_off_to_post", M_POST, 0, 0, 1, 0);
    bus.i_enable = 1'b1;
    room = 25;
    do_tick(9);
    expect_st("cool_before_stall", M_COOL, 0, 1, 1, 0);

    // Sensor stall
    stall_tick(9);
    expect_st("stall_9_ticks", M_COOL, 0, 1, 1, 0);
    stall_tick(1);
    expect_st("stall_fault", M_FAULT, 0, 0, 0, 1);
    cyc(1'b0, 1'b1, room);
    expect_st("fault_recover", M_LOCK, 0, 0, 0, 0);

    // Setpoint floor at zero
    bus.i_setpoint = 7'd0;
    room = 0;
    do_tick(6);
    expect_st("sp0_temp0_heat", M_HEAT, 1, 0, 1, 0);
    do_tick(4);
    expect_st("sp0_heat_exit", M_POST, 0, 0, 1, 0);
    room = 1;
    do_tick(9);
    expect_st("sp0_temp1_cool", M_COOL, 0, 1, 1, 0);

    // Sample and tick together clear the watchdog
    stall_tick(8);
    cyc(1'b1, 1'b1, room);
    cyc(1'b0, 1'b0, room);
    cyc(1'b0, 1'b0, room);
    stall_tick(9);
    expect_st("valid_beats_tick", M_COOL, 0, 1, 1, 0);
    stall_tick(1);
    expect_st("valid_beats_tick_fault", M_FAULT, 0, 0, 0, 1);
    cyc(1'b0, 1'b1, room);
    do_tick(6);
    expect_st("cool_before_reset", M_COOL, 0, 1, 1, 0);

    // Asynchronous reset mid-cool
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_reset_outputs", dut_code(), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    stall_tick(3);
    expect_st("no_demand_without_sample", M_IDLE, 0, 0, 0, 0);
    cyc(1'b0, 1'b1, room);
    cyc(1'b0, 1'b0, room);
    expect_st("first_sample_after_reset", M_COOL, 0, 1, 1, 0);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
